// File: rtl/rr_delayed_grant_arbiter_pkg.sv
// Shared types and defaults for the delayed-grant round-robin arbiter.
package arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WAIT  = 2'd1,
      GRANT = 2'd2
   } arb_state_e;

   localparam int GNT_DLY_DEF  = 2;
   localparam int HOLD_MAX_DEF = 8;
   localparam int DLY_W        = 4;   // holds GNT_DLY-1 for GNT_DLY up to 15
   localparam int HOLD_W       = 8;   // holds HOLD_MAX-1 for HOLD_MAX up to 255

endpackage

// File: rtl/rr_delayed_grant_arbiter_rr_pick.sv
// Round-robin winner search: rotate so last_id+1 sits at bit 0,
// take the lowest set bit, then rotate the index back.
module rr_pick #(
   parameter int NREQ = 4,
   parameter int IDW  = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [IDW-1:0]  last_id,
   output logic            found,
   output logic [IDW-1:0]  winner
);

   logic [NREQ-1:0] rot;
   logic [IDW-1:0]  off;
   logic [IDW-1:0]  pos;

   always_comb begin
      rot = '0;
      pos = '0;
      for (int i = 0; i < NREQ; i++) begin
         pos    = IDW'((int'(last_id) + 1 + i) % NREQ);
         rot[i] = req[pos];
      end
   end

   // Descending scan so the lowest rotated index is the one left standing.
   always_comb begin
      found = 1'b0;
      off   = '0;
      for (int i = NREQ - 1; i >= 0; i--) begin
         if (rot[i]) begin
            found = 1'b1;
            off   = IDW'(i);
         end
      end
   end

   assign winner = IDW'((int'(last_id) + 1 + int'(off)) % NREQ);

endmodule

// File: rtl/rr_delayed_grant_arbiter.sv
// Round-robin arbiter with a fixed request-to-grant delay, owner release via
// done, and a forced release after HOLD_MAX grant cycles.
module rr_delayed_grant_arbiter
   import arb_pkg::*;
#(
   parameter int NREQ     = 4,
   parameter int GNT_DLY  = GNT_DLY_DEF,
   parameter int HOLD_MAX = HOLD_MAX_DEF,
   parameter int IDW      = $clog2(NREQ)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [NREQ-1:0] req,
   input  logic [NREQ-1:0] done,
   output logic [NREQ-1:0] gnt,
   output logic [IDW-1:0]  gnt_id,
   output logic            busy,
   output logic            timeout,
   output logic            abort
);

   arb_state_e        state, state_nxt;
   logic [IDW-1:0]    last_id, last_id_nxt;
   logic [DLY_W-1:0]  dly_cnt, dly_nxt;
   logic [HOLD_W-1:0] hold_cnt, hold_nxt;
   logic [NREQ-1:0]   gnt_nxt;
   logic [IDW-1:0]    gnt_id_nxt;
   logic              busy_nxt, timeout_nxt, abort_nxt;

   logic              found;
   logic [IDW-1:0]    winner;
   logic              owner_req, owner_done;

   rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_pick (
      .req     (req),
      .last_id (last_id),
      .found   (found),
      .winner  (winner)
   );

   assign owner_req  = req[gnt_id];
   assign owner_done = done[gnt_id];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         last_id  <= IDW'(NREQ - 1);
         dly_cnt  <= '0;
         hold_cnt <= '0;
         gnt      <= '0;
         gnt_id   <= '0;
         busy     <= 1'b0;
         timeout  <= 1'b0;
         abort    <= 1'b0;
      end else begin
         state    <= state_nxt;
         last_id  <= last_id_nxt;
         dly_cnt  <= dly_nxt;
         hold_cnt <= hold_nxt;
         gnt      <= gnt_nxt;
         gnt_id   <= gnt_id_nxt;
         busy     <= busy_nxt;
         timeout  <= timeout_nxt;
         abort    <= abort_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (found) state_nxt = WAIT;
         WAIT: begin
            if (!owner_req)          state_nxt = IDLE;
            else if (dly_cnt == '0)  state_nxt = GRANT;
         end
         GRANT:   if (owner_done || hold_cnt == '0) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      gnt_nxt     = gnt;
      gnt_id_nxt  = gnt_id;
      busy_nxt    = busy;
      timeout_nxt = 1'b0;
      abort_nxt   = 1'b0;
      last_id_nxt = last_id;
      dly_nxt     = dly_cnt;
      hold_nxt    = hold_cnt;
      case (state)
         IDLE: begin
            gnt_nxt  = '0;
            busy_nxt = 1'b0;
            if (found) begin
               gnt_id_nxt = winner;
               busy_nxt   = 1'b1;
               dly_nxt    = DLY_W'(GNT_DLY - 1);
            end
         end
         WAIT: begin
            // Abort leaves last_id alone so the same requester keeps its turn.
            if (!owner_req) begin
               abort_nxt = 1'b1;
               busy_nxt  = 1'b0;
            end else if (dly_cnt == '0) begin
               gnt_nxt         = '0;
               gnt_nxt[gnt_id] = 1'b1;
               hold_nxt        = HOLD_W'(HOLD_MAX - 1);
            end else begin
               dly_nxt = dly_cnt - 1'b1;
            end
         end
         GRANT: begin
            if (owner_done) begin
               gnt_nxt     = '0;
               busy_nxt    = 1'b0;
               last_id_nxt = gnt_id;
            end else if (hold_cnt == '0) begin
               gnt_nxt     = '0;
               busy_nxt    = 1'b0;
               timeout_nxt = 1'b1;
               last_id_nxt = gnt_id;
            end else begin
               hold_nxt = hold_cnt - 1'b1;
            end
         end
         default: begin
            gnt_nxt  = '0;
            busy_nxt = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_rr_delayed_grant_arbiter.sv
// Directed bench for rr_delayed_grant_arbiter with NREQ=4, GNT_DLY=2, HOLD_MAX=8.
module tb_rr_delayed_grant_arbiter;

   logic       clk;
   logic       rst_n;
   logic [3:0] req;
   logic [3:0] done;
   logic [3:0] gnt;
   logic [1:0] gnt_id;
   logic       busy;
   logic       timeout;
   logic       abort;

   int tests = 0;
   int fails = 0;

   rr_delayed_grant_arbiter #(.NREQ(4), .GNT_DLY(2), .HOLD_MAX(8)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .req     (req),
      .done    (done),
      .gnt     (gnt),
      .gnt_id  (gnt_id),
      .busy    (busy),
      .timeout (timeout),
      .abort   (abort)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance one edge, then check the invariants on the freshly updated outputs.
   task automatic tick();
      @(posedge clk);
      #1;
      chk("onehot0_gnt", 32'($onehot0(gnt)), 32'd1);
      chk("gnt_implies_busy", 32'(gnt == 4'b0 || busy), 32'd1);
      chk("not_timeout_and_abort", 32'(timeout && abort), 32'd0);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   // Request sampled at edge T, gnt register high after T+2, done sampled at T+5.
   task automatic grant_cycle(input logic [3:0] r, input int id);
      logic [3:0] oh;
      oh  = 4'b0001 << id;
      req = r;
      tick();
      chk("arb_busy", 32'(busy), 32'd1);
      chk("arb_gnt_id", 32'(gnt_id), 32'(id));
      chk("wait_gnt_low", 32'(gnt), 32'd0);
      tick();
      chk("wait_gnt_low2", 32'(gnt), 32'd0);
      tick();
      chk("gnt_onehot", 32'(gnt), 32'(oh));
      tick();
      tick();
      done = oh;
      tick();
      done = 4'b0;
      chk("rel_gnt", 32'(gnt), 32'd0);
      chk("rel_busy", 32'(busy), 32'd0);
      chk("rel_timeout", 32'(timeout), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0;
      req   = 4'b0;
      done  = 4'b0;
      #3;
      chk("rst_gnt", 32'(gnt), 32'd0);
      chk("rst_gnt_id", 32'(gnt_id), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_timeout", 32'(timeout), 32'd0);
      chk("rst_abort", 32'(abort), 32'd0);
      tick();
      rst_n = 1'b1;
      tick();

      // Single request from reset: requester 0 has first priority.
      grant_cycle(4'b0001, 0);
      req = 4'b0;

      // Fairness from a fresh pointer, then skip and wrap with 0101.
      do_reset();
      grant_cycle(4'b1111, 0);
      grant_cycle(4'b1111, 1);
      grant_cycle(4'b1111, 2);
      grant_cycle(4'b1111, 3);
      grant_cycle(4'b0101, 0);
      grant_cycle(4'b0101, 2);
      grant_cycle(4'b0101, 0);
      req = 4'b0;
      tick();
      chk("idle_busy", 32'(busy), 32'd0);

      // Timeout: gnt[1] high for 8 sampled edges; a non-owner done is ignored.
      req = 4'b0010;
      tick();
      chk("to_gnt_id", 32'(gnt_id), 32'd1);
      tick();
      tick();
      for (int i = 0; i < 8; i++) begin
         chk("to_gnt_held", 32'(gnt), 32'h2);
         chk("to_no_timeout", 32'(timeout), 32'd0);
         done = (i == 3) ? 4'b0001 : 4'b0000;
         tick();
      end
      done = 4'b0;
      chk("to_gnt_clr", 32'(gnt), 32'd0);
      chk("to_pulse", 32'(timeout), 32'd1);
      chk("to_busy", 32'(busy), 32'd0);
      req = 4'b0;
      tick();
      chk("to_pulse_end", 32'(timeout), 32'd0);

      // Abort with last_id=1: winner 2 drops its request in WAIT.
      req = 4'b0100;
      tick();
      chk("ab_gnt_id", 32'(gnt_id), 32'd2);
      req = 4'b0;
      tick();
      chk("ab_pulse", 32'(abort), 32'd1);
      chk("ab_busy", 32'(busy), 32'd0);
      chk("ab_gnt", 32'(gnt), 32'd0);
      tick();
      chk("ab_pulse_end", 32'(abort), 32'd0);
      // Pointer still at 1, so 0110 must pick 2 rather than 1.
      grant_cycle(4'b0110, 2);

      // done on the same edge the hold counter expires: done wins.
      req = 4'b0010;
      tick();
      chk("dt_gnt_id", 32'(gnt_id), 32'd1);
      tick();
      tick();
      repeat (7) tick();
      chk("dt_gnt_last", 32'(gnt), 32'h2);
      done = 4'b0010;
      req  = 4'b0;
      tick();
      done = 4'b0;
      chk("dt_gnt_clr", 32'(gnt), 32'd0);
      chk("dt_no_timeout", 32'(timeout), 32'd0);
      chk("dt_busy", 32'(busy), 32'd0);

      // Reset while requester 3 holds the grant.
      req = 4'b1000;
      tick();
      chk("rg_gnt_id", 32'(gnt_id), 32'd3);
      tick();
      tick();
      chk("rg_gnt", 32'(gnt), 32'h8);
      rst_n = 1'b0;
      #1;
      chk("rg_async_gnt", 32'(gnt), 32'd0);
      chk("rg_async_busy", 32'(busy), 32'd0);
      chk("rg_async_id", 32'(gnt_id), 32'd0);
      req = 4'b0;
      tick();
      rst_n = 1'b1;
      grant_cycle(4'b1001, 0);
      req = 4'b0;
      tick();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/rr_delayed_grant_arbiter.md
Name: rr_delayed_grant_arbiter

Overview:
- Round-robin arbiter sharing one resource among NREQ requesters using the req/gnt handshake the team checks with SVA: a grant is sampled exactly GNT_DLY cycles after the cycle following the sampled request (default: req |=> ##2 gnt).
- Holds the grant until the owner pulses done, or until a hold timeout expires.
- Sits between requesting masters and the shared resource, and drives the resource's select/enable.

Parameters:
- NREQ, 4, number of requesters (2..16).
- GNT_DLY, 2, cycles between the cycle after the sampled request and the sampled gnt (1..15).
- HOLD_MAX, 8, maximum grant-high cycles before forced release (1..255).
- IDW, $clog2(NREQ), width of the granted-index output.

Ports:
- clk  in  1  single clock; all state updates on posedge.
- rst_n  in  1  asynchronous active-low reset.
- req  in  NREQ  level request per requester; held until done or withdrawn.
- done  in  NREQ  one-cycle release pulse from the current owner; ignored from non-owners.
- gnt  out  NREQ  one-hot grant, all-zero when idle.
- gnt_id  out  IDW  index of the latched winner; valid while busy=1.
- busy  out  1  high in WAIT and GRANT.
- timeout  out  1  one-cycle pulse when HOLD_MAX forces release.
- abort  out  1  one-cycle pulse when the winner withdraws req during WAIT.

Behaviour:
- Reset (async assert, sync-deasserted externally):
  - gnt=0, gnt_id=0, busy=0, timeout=0, abort=0.
  - state=IDLE, last_id=NREQ-1, so requester 0 has first priority.
- Outputs registered; no combinational input-to-output path.
- FSM IDLE -> WAIT -> GRANT -> IDLE.
- IDLE:
  - At edge T with any req bit high, select the first set bit searching last_id+1, last_id+2, ... modulo NREQ.
  - Latch winner into gnt_id, set busy=1, load dly_cnt=GNT_DLY-1, go to WAIT.
  - If req=0: stay in IDLE, outputs quiet.
- WAIT:
  - Count dly_cnt down to 0. At the edge with dly_cnt=0 and req[gnt_id]=1, set gnt[gnt_id]=1, load hold_cnt=HOLD_MAX-1, go to GRANT.
  - Result: gnt is first sampled high at edge T+1+GNT_DLY.
  - Winner's req low at any WAIT edge: abort=1 for one cycle, busy=0, go to IDLE, last_id unchanged, no grant issued.
  - Other requesters' req changes are ignored; no preemption.
- GRANT:
  - done[gnt_id]=1 sampled: gnt cleared at that edge, last_id=gnt_id, busy=0, go to IDLE.
  - Otherwise, if hold_cnt=0: gnt cleared, timeout=1 for one cycle, last_id=gnt_id, go to IDLE.
  - Otherwise decrement hold_cnt.
  - Net effect: gnt is high for at most HOLD_MAX sampled edges.
- done and the timeout expiry on the same edge: done wins, timeout stays 0.
- req[gnt_id] dropping during GRANT without done has no effect; the grant runs to done or timeout.
- Back-to-back grants:
  - IDLE always spends at least one cycle, so there is at least one gnt-low sampled edge between owners.
  - The next arbitration uses the updated last_id.
- Wrap-around: pointer search is modulo NREQ; a single persistent requester is re-granted every cycle in which it is the only requester.
- Reset mid-WAIT or mid-GRANT: gnt drops immediately (async), and the pointer returns to NREQ-1.
- Invariants checked by the bench:
  - $onehot0(gnt).
  - gnt!=0 implies busy.
  - timeout and abort are never both high.

Decomposition:
- Shared package arb_pkg holds:
  - typedef enum logic [1:0] {IDLE, WAIT, GRANT} arb_state_e.
  - Localparam defaults for GNT_DLY and HOLD_MAX.
- One natural sub-module: rr_pick.
  - Combinational: given req, last_id and NREQ, returns found and a winner index via rotate, priority-encode, un-rotate.
  - Instantiated once in the arbiter.

Test Plan:
- Single request: req=4'b0001 sampled at edge T -> gnt=4'b0001 sampled at T+3, gnt_id=0, busy=1 from T+1; done[0] pulse at T+5 -> gnt=0 at T+6, no timeout.
- Round-robin fairness: req=4'b1111 held, each owner pulses done two cycles after gnt -> grant order 0,1,2,3,0, one idle cycle between owners.
- Pointer skip and wrap: after owner 3 releases, req=4'b0101 -> requester 0 granted; after its release -> requester 2 granted.
- Timeout: req=4'b0010, never done, HOLD_MAX=8 -> gnt[1] high for exactly 8 edges, timeout pulses once, then gnt=0 and last_id=1.
- Abort: req[2] raised, winner=2, req[2] dropped at T+2 -> abort pulse, no gnt, busy=0; next arbitration with req=4'b0100 again grants 2 (pointer not advanced).
- Reset mid-GRANT: rst_n low while gnt=4'b1000 -> gnt=0 immediately; after release, req=4'b1001 -> requester 0 granted first.
